eager_fork_data: RTL and testbench

Elastic eager fork: replicates one valid/ready input token of `DATA_TYPE` bits onto `SIZE` output channels. Each output completes its handshake independently, and the input is consumed only once every output has accepted the token. It is the dual of the join in front of our arithmetic units: it distributes one producer's result (e.g. a `minimumf` output) to several consumers without deadlock when those consumers stall at different times.

---
 rtl/eager_fork_data.sv | 38 +++
 tb/tb_eager_fork_data.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eager_fork_data.sv
// Elastic eager fork: one valid/ready input token replicated onto SIZE outputs.
// Each output handshakes independently; the input retires once all have taken it.
module eager_fork_data #(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_TYPE-1:0]      ins,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  output logic [SIZE*DATA_TYPE-1:0] outs,
  output logic [SIZE-1:0]           outs_valid,
  input  logic [SIZE-1:0]           outs_ready
);

  logic [SIZE-1:0] r_sent;
  logic [SIZE-1:0] w_done;
  logic            w_complete;

  assign outs       = {SIZE{ins}};
  assign outs_valid = {SIZE{ins_valid}} & ~r_sent;
  assign w_done     = r_sent | outs_ready;
  assign w_complete = ins_valid & (&w_done);
  assign ins_ready  = w_complete;

  // Flags clear on completion so the next token needs no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sent <= '0;
    end else if (w_complete) begin
      r_sent <= '0;
    end else begin
      r_sent <= r_sent | (outs_valid & outs_ready);
    end
  end

endmodule

// File: tb/tb_eager_fork_data.sv
// Directed bench for eager_fork_data at SIZE=3, SIZE=2 and SIZE=1.
module tb_eager_fork_data;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] d3_ins = '0;
  logic        d3_iv  = 1'b0;
  logic        d3_ir;
  logic [95:0] d3_outs;
  logic [2:0]  d3_ov;
  logic [2:0]  d3_or  = '0;

  logic [31:0] d2_ins = '0;
  logic        d2_iv  = 1'b0;
  logic        d2_ir;
  logic [63:0] d2_outs;
  logic [1:0]  d2_ov;
  logic [1:0]  d2_or  = '0;

  logic [15:0] d1_ins = '0;
  logic        d1_iv  = 1'b0;
  logic        d1_ir;
  logic [15:0] d1_outs;
  logic        d1_ov;
  logic        d1_or  = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  eager_fork_data #(.SIZE(3), .DATA_TYPE(32)) u3 (
    .clk(clk), .rst(rst), .ins(d3_ins), .ins_valid(d3_iv),
    .ins_ready(d3_ir), .outs(d3_outs), .outs_valid(d3_ov),
    .outs_ready(d3_or)
  );

  eager_fork_data #(.SIZE(2), .DATA_TYPE(32)) u2 (
    .clk(clk), .rst(rst), .ins(d2_ins), .ins_valid(d2_iv),
    .ins_ready(d2_ir), .outs(d2_outs), .outs_valid(d2_ov),
    .outs_ready(d2_or)
  );

  eager_fork_data #(.SIZE(1), .DATA_TYPE(16)) u1 (
    .clk(clk), .rst(rst), .ins(d1_ins), .ins_valid(d1_iv),
    .ins_ready(d1_ir), .outs(d1_outs), .outs_valid(d1_ov),
    .outs_ready(d1_or)
  );

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_total++;
    if (d3_ov !== 3'b000 || d3_ir !== 1'b0) begin
      $display("FAIL reset_idle: ov=%b ir=%b want ov=000 ir=0", d3_ov, d3_ir);
    end else n_pass++;
    d3_iv = 1'b1;
    d3_ins = 32'h1234_5678;
    #1;
    n_total++;
    if (d3_ov !== 3'b111 || d3_ir !== 1'b0 ||
        d3_outs !== {3{32'h1234_5678}}) begin
      $display("FAIL reset_valid: ov=%b ir=%b outs=%h want ov=111 ir=0",
               d3_ov, d3_ir, d3_outs);
    end else n_pass++;
    d3_iv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_all_ready();
    logic [31:0] v;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      v = 32'(k);
      d3_ins = v;
      d3_iv  = 1'b1;
      d3_or  = 3'b111;
      @(negedge clk);
      n_total++;
      if (d3_outs !== {3{v}} || d3_ov !== 3'b111 || d3_ir !== 1'b1) begin
        $display("FAIL all_ready_%0d: outs=%h ov=%b ir=%b want outs=%h ov=111 ir=1",
                 k, d3_outs, d3_ov, d3_ir, {3{v}});
      end else n_pass++;
    end
    @(posedge clk);
    #1;
    d3_iv = 1'b0;
    d3_or = 3'b000;
  endtask

  task automatic test_staggered();
    logic [2:0] rdy [3];
    logic [2:0] exp_ov [3];
    logic       exp_ir [3];
    int         cnt [3];
    rdy[0] = 3'b001; exp_ov[0] = 3'b111; exp_ir[0] = 1'b0;
    rdy[1] = 3'b100; exp_ov[1] = 3'b110; exp_ir[1] = 1'b0;
    rdy[2] = 3'b010; exp_ov[2] = 3'b010; exp_ir[2] = 1'b1;
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      d3_ins = 32'hDEAD_BEEF;
      d3_iv  = 1'b1;
      d3_or  = rdy[k];
      @(negedge clk);
      for (int c = 0; c < 3; c++) if (d3_ov[c] && d3_or[c]) cnt[c]++;
      n_total++;
      if (d3_ov !== exp_ov[k] || d3_ir !== exp_ir[k]) begin
        $display("FAIL stagger_c%0d: ov=%b ir=%b want ov=%b ir=%b",
                 k, d3_ov, d3_ir, exp_ov[k], exp_ir[k]);
      end else n_pass++;
    end
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (cnt[c] != 1) begin
        $display("FAIL stagger_xfer_ch%0d: got %0d transfers want 1", c, cnt[c]);
      end else n_pass++;
    end
    @(posedge clk);
    #1;
    d3_ins = 32'h0000_0007;
    d3_or  = 3'b000;
    @(negedge clk);
    n_total++;
    if (d3_ov !== 3'b111 || d3_ir !== 1'b0) begin
      $display("FAIL stagger_fresh: ov=%b ir=%b want ov=111 ir=0", d3_ov, d3_ir);
    end else n_pass++;
    @(posedge clk);
    #1;
    d3_iv = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ch0_a = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      d2_ins = 32'hA;
      d2_iv  = 1'b1;
      d2_or  = (k == 4) ? 2'b11 : 2'b01;
      @(negedge clk);
      if (d2_ov[0] && d2_or[0]) ch0_a++;
      n_total++;
      if (d2_ov !== ((k == 0) ? 2'b11 : 2'b10) ||
          d2_ir !== (k == 4) || d2_outs !== {2{32'hA}}) begin
        $display("FAIL b2b_a_c%0d: ov=%b ir=%b outs=%h", k, d2_ov, d2_ir, d2_outs);
      end else n_pass++;
    end
    n_total++;
    if (ch0_a != 1) begin
      $display("FAIL b2b_no_dup: ch0 took 0xA %0d times want 1", ch0_a);
    end else n_pass++;
    @(posedge clk);
    #1;
    d2_ins = 32'hB;
    d2_or  = 2'b11;
    @(negedge clk);
    n_total++;
    if (d2_ov !== 2'b11 || d2_ir !== 1'b1 || d2_outs !== {2{32'hB}}) begin
      $display("FAIL b2b_b: ov=%b ir=%b outs=%h want ov=11 ir=1 outs=%h",
               d2_ov, d2_ir, d2_outs, {2{32'hB}});
    end else n_pass++;
    @(posedge clk);
    #1;
    d2_iv = 1'b0;
    d2_or = 2'b00;
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    d2_ins = 32'h55;
    d2_iv  = 1'b1;
    d2_or  = 2'b01;
    @(posedge clk);
    #1;
    d2_or = 2'b00;
    #1;
    n_total++;
    if (d2_ov !== 2'b10 || d2_ir !== 1'b0) begin
      $display("FAIL rstmid_pre: ov=%b ir=%b want ov=10 ir=0", d2_ov, d2_ir);
    end else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if (d2_ov !== 2'b11 || d2_outs !== {2{32'h55}}) begin
      $display("FAIL rstmid_async: ov=%b outs=%h want ov=11", d2_ov, d2_outs);
    end else n_pass++;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    d2_iv = 1'b0;
  endtask

  task automatic test_ready_no_valid();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      d3_iv = 1'b0;
      d3_or = 3'b111;
      @(negedge clk);
      n_total++;
      if (d3_ov !== 3'b000 || d3_ir !== 1'b0) begin
        $display("FAIL novalid_c%0d: ov=%b ir=%b want ov=000 ir=0", k, d3_ov, d3_ir);
      end else n_pass++;
    end
    @(posedge clk);
    #1;
    d3_iv = 1'b1;
    d3_or = 3'b000;
    @(negedge clk);
    n_total++;
    if (d3_ov !== 3'b111) begin
      $display("FAIL novalid_sent: ov=%b want 111", d3_ov);
    end else n_pass++;
    @(posedge clk);
    #1;
    d3_iv = 1'b0;
  endtask

  task automatic test_degenerate();
    int  tok_in  = 0;
    int  tok_out = 0;
    int  errs    = 0;
    logic took   = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (!d1_iv || took) begin
        d1_iv  = 1'($urandom_range(0, 1));
        d1_ins = 16'($urandom);
      end
      d1_or = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (d1_outs !== d1_ins || d1_ov !== d1_iv ||
          d1_ir !== (d1_iv & d1_or)) begin
        if (errs < 5)
          $display("FAIL deg_c%0d: outs=%h ov=%b ir=%b in=%h iv=%b or=%b",
                   k, d1_outs, d1_ov, d1_ir, d1_ins, d1_iv, d1_or);
        errs++;
      end
      took = d1_iv & d1_ir;
      if (d1_iv && d1_ir) tok_in++;
      if (d1_ov && d1_or) tok_out++;
    end
    n_total++;
    if (errs != 0) begin
      $display("FAIL deg_wire: %0d bad cycles want 0", errs);
    end else n_pass++;
    n_total++;
    if (tok_in != tok_out || tok_in == 0) begin
      $display("FAIL deg_count: in=%0d out=%0d want equal and nonzero",
               tok_in, tok_out);
    end else n_pass++;
    @(posedge clk);
    #1;
    d1_iv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_ready();
    test_staggered();
    test_back_to_back();
    test_reset_mid();
    test_ready_no_valid();
    test_degenerate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
